// File: rtl/dl166_pkg.sv
// Shared DL166 definitions: FSM state and command encodings, widths, and the
// per-state control decode used by the program controller.
package dl166_pkg;

    localparam int DL166_ADDR_W  = 4;
    localparam int DL166_INSTR_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_STEP = 3'd3,
        ST_HALT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CMD_HALT = 2'b00,
        CMD_LOAD = 2'b01,
        CMD_RUN  = 2'b10,
        CMD_STEP = 2'b11
    } cmd_t;

    typedef struct packed {
        logic cpu_reset;
        logic clk_en;
        logic cmd_ready;
        logic wr_ready;
    } ctrl_t;

    // Control outputs registered alongside the state they belong to.
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '{cpu_reset: 1'b0, clk_en: 1'b1, cmd_ready: 1'b1, wr_ready: 1'b0};
        case (s)
            ST_IDLE: c = '{cpu_reset: 1'b0, clk_en: 1'b1, cmd_ready: 1'b1, wr_ready: 1'b0};
            ST_LOAD: c = '{cpu_reset: 1'b0, clk_en: 1'b1, cmd_ready: 1'b0, wr_ready: 1'b1};
            ST_RUN:  c = '{cpu_reset: 1'b1, clk_en: 1'b1, cmd_ready: 1'b1, wr_ready: 1'b0};
            ST_STEP: c = '{cpu_reset: 1'b1, clk_en: 1'b1, cmd_ready: 1'b0, wr_ready: 1'b0};
            ST_HALT: c = '{cpu_reset: 1'b1, clk_en: 1'b0, cmd_ready: 1'b1, wr_ready: 1'b0};
            default: c = '{cpu_reset: 1'b0, clk_en: 1'b1, cmd_ready: 1'b1, wr_ready: 1'b0};
        endcase
        return c;
    endfunction

    function automatic state_t cmd_target(input cmd_t c);
        state_t s;
        s = ST_HALT;
        case (c)
            CMD_HALT: s = ST_HALT;
            CMD_LOAD: s = ST_LOAD;
            CMD_RUN:  s = ST_RUN;
            CMD_STEP: s = ST_STEP;
            default:  s = ST_HALT;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/dl166_prog_mem.sv
// DL166 instruction store: flop array with synchronous write, asynchronous
// read, and every word cleared to 0x00 (a no-op) by the active-low reset.
module dl166_prog_mem
    import dl166_pkg::*;
#(
    parameter int ADDR_W = DL166_ADDR_W,
    parameter int DATA_W = DL166_INSTR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_adr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_adr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2**ADDR_W; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_adr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_adr];

endmodule

// File: rtl/dl166_prog_ctrl.sv
// DL166 program-memory controller and run sequencer.
// Optional breakpoint comparator enabled by defining DL166_PROG_CTRL_BP_EN.
module dl166_prog_ctrl
    import dl166_pkg::*;
#(
    parameter int DEPTH_LOG2 = DL166_ADDR_W,
    parameter int IWIDTH     = DL166_INSTR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            cmd,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [IWIDTH-1:0]     wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DEPTH_LOG2-1:0] cpu_adr,
    output logic [IWIDTH-1:0]     cpu_dout,
    output logic                  cpu_reset,
    output logic                  cpu_clk_en,
    output logic [2:0]            state,
    output logic                  load_done,
    input  logic [DEPTH_LOG2-1:0] bp_adr,
    output logic                  bp_hit
);

    state_t                state_q;
    state_t                next_state;
    ctrl_t                 ctrl_q;
    logic                  load_done_q;
    logic [DEPTH_LOG2-1:0] wptr;
    cmd_t                  cmd_e;
    logic                  cmd_acc;
    logic                  run_cmd_switch;
    logic                  mem_we;
    logic                  last_beat;
    logic                  bp_match;

    assign cmd_e          = cmd_t'(cmd);
    assign cmd_acc        = cmd_valid && ctrl_q.cmd_ready;
    assign run_cmd_switch = cmd_acc && (cmd_e != CMD_RUN);
    assign mem_we         = wr_valid && ctrl_q.wr_ready;
    assign last_beat      = mem_we && (wptr == {DEPTH_LOG2{1'b1}});

    always_comb begin
        next_state = state_q;
        case (state_q)
            ST_IDLE: if (cmd_acc) next_state = cmd_target(cmd_e);
            ST_LOAD: if (last_beat) next_state = ST_IDLE;
            ST_RUN: begin
                // An explicit command outranks a breakpoint in the same cycle.
                if (run_cmd_switch) begin
                    next_state = cmd_target(cmd_e);
                end else if (bp_match) begin
                    next_state = ST_HALT;
                end
            end
            ST_STEP: next_state = ST_HALT;
            ST_HALT: if (cmd_acc && (cmd_e != CMD_HALT)) next_state = cmd_target(cmd_e);
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            ctrl_q      <= state_ctrl(ST_IDLE);
            load_done_q <= 1'b0;
            wptr        <= '0;
        end else begin
            state_q     <= next_state;
            ctrl_q      <= state_ctrl(next_state);
            load_done_q <= (state_q == ST_LOAD) && last_beat;
            if ((next_state == ST_LOAD) && (state_q != ST_LOAD)) begin
                wptr <= '0;
            end else if (mem_we) begin
                wptr <= wptr + 1'b1;
            end
        end
    end

    dl166_prog_mem #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (IWIDTH)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (mem_we),
        .wr_adr  (wptr),
        .wr_data (wr_data),
        .rd_adr  (cpu_adr),
        .rd_data (cpu_dout)
    );

`ifdef DL166_PROG_CTRL_BP_EN
    logic bp_hit_q;
    logic first_run_q;

    // Masking the first RUN cycle lets a resume from the breakpoint address proceed.
    assign bp_match = (state_q == ST_RUN) && !first_run_q && (cpu_adr == bp_adr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bp_hit_q    <= 1'b0;
            first_run_q <= 1'b0;
        end else begin
            first_run_q <= (next_state == ST_RUN) && (state_q != ST_RUN);
            if ((state_q == ST_RUN) && bp_match && !run_cmd_switch) begin
                bp_hit_q <= 1'b1;
            end else if (cmd_acc && ((cmd_e == CMD_RUN) || (cmd_e == CMD_STEP))) begin
                bp_hit_q <= 1'b0;
            end
        end
    end

    assign cpu_clk_en = ctrl_q.clk_en && !bp_match;
    assign bp_hit     = bp_hit_q;
`else
    logic unused_bp_adr;

    assign unused_bp_adr = ^bp_adr;
    assign bp_match      = 1'b0;
    assign cpu_clk_en    = ctrl_q.clk_en;
    assign bp_hit        = 1'b0;
`endif

    assign cmd_ready = ctrl_q.cmd_ready;
    assign wr_ready  = ctrl_q.wr_ready;
    assign cpu_reset = ctrl_q.cpu_reset;
    assign state     = state_q;
    assign load_done = load_done_q;

endmodule

// File: tb/tb_dl166_prog_ctrl.sv
// Directed testbench for dl166_prog_ctrl; breakpoint steps are included when
// DL166_PROG_CTRL_BP_EN is defined.
module tb_dl166_prog_ctrl;

    localparam logic [1:0] C_HALT = 2'b00;
    localparam logic [1:0] C_LOAD = 2'b01;
    localparam logic [1:0] C_RUN  = 2'b10;
    localparam logic [1:0] C_STEP = 2'b11;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] wr_data = 8'h00;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [3:0] cpu_adr = 4'd0;
    logic [7:0] cpu_dout;
    logic       cpu_reset;
    logic       cpu_clk_en;
    logic [2:0] state;
    logic       load_done;
    logic [3:0] bp_adr = 4'd3;
    logic       bp_hit;

    int total = 0;
    int bad = 0;

    dl166_prog_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .cpu_adr    (cpu_adr),
        .cpu_dout   (cpu_dout),
        .cpu_reset  (cpu_reset),
        .cpu_clk_en (cpu_clk_en),
        .state      (state),
        .load_done  (load_done),
        .bp_adr     (bp_adr),
        .bp_hit     (bp_hit)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] c);
        cmd       = c;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic readCheck(input string tag, input logic [3:0] adr, input logic [7:0] expected);
        cpu_adr = adr;
        #1;
        checkOutput(tag, {24'd0, cpu_dout}, {24'd0, expected});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting dl166_prog_ctrl directed test");
        tick();
        tick();
        reset = 1'b1;
        tick();

        checkOutput("rst_state",     {29'd0, state},    32'd0);
        checkOutput("rst_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        checkOutput("rst_clk_en",    {31'd0, cpu_clk_en}, 32'd1);
        checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("rst_wr_ready",  {31'd0, wr_ready},  32'd0);
        checkOutput("rst_load_done", {31'd0, load_done}, 32'd0);
        checkOutput("rst_bp_hit",    {31'd0, bp_hit},    32'd0);
        readCheck("rst_mem0", 4'd0, 8'h00);
        tick();

        // Load 0xA0..0xAF with wr_valid held high
        cpu_adr = 4'd0;
        applyStimulus(C_LOAD);
        checkOutput("load_state",     {29'd0, state},    32'd1);
        checkOutput("load_wr_ready",  {31'd0, wr_ready},  32'd1);
        checkOutput("load_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        checkOutput("load_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        wr_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_data = 8'hA0 + 8'(i);
            if (i == 15) checkOutput("load_pre_last_state", {29'd0, state}, 32'd1);
            tick();
            if (i == 0) checkOutput("load_latency_adr0", {24'd0, cpu_dout}, 32'hA0);
        end
        wr_valid = 1'b0;
        checkOutput("load_done_pulse", {31'd0, load_done}, 32'd1);
        checkOutput("load_end_state",  {29'd0, state},     32'd0);
        checkOutput("load_end_wr_rdy", {31'd0, wr_ready},  32'd0);
        readCheck("load_adr5", 4'd5, 8'hA5);
        readCheck("load_adr15", 4'd15, 8'hAF);
        tick();
        checkOutput("load_done_drop", {31'd0, load_done}, 32'd0);

        // Load with wr_valid toggling every other cycle
        applyStimulus(C_LOAD);
        for (int c = 0; c < 31; c++) begin
            checkOutput("tog_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            wr_valid = ((c % 2) == 0);
            wr_data  = 8'h50 + 8'(c / 2);
            tick();
        end
        wr_valid = 1'b0;
        checkOutput("tog_state_idle", {29'd0, state},     32'd0);
        checkOutput("tog_load_done",  {31'd0, load_done}, 32'd1);
        for (int a = 0; a < 16; a++) begin
            readCheck("tog_mem", 4'(a), 8'h50 + 8'(a));
        end
        tick();

        // Beats presented outside LOAD are dropped
        cpu_adr  = 4'd0;
        wr_valid = 1'b1;
        wr_data  = 8'hFF;
        tick();
        wr_valid = 1'b0;
        checkOutput("drop_wr_ready", {31'd0, wr_ready}, 32'd0);
        checkOutput("drop_mem0", {24'd0, cpu_dout}, 32'h50);

        // Single step from IDLE
        applyStimulus(C_STEP);
        checkOutput("step_state",     {29'd0, state},      32'd3);
        checkOutput("step_clk_en",    {31'd0, cpu_clk_en}, 32'd1);
        checkOutput("step_cpu_reset", {31'd0, cpu_reset},  32'd1);
        checkOutput("step_cmd_ready", {31'd0, cmd_ready},  32'd0);
        tick();
        checkOutput("step_halt_state",  {29'd0, state},      32'd4);
        checkOutput("step_halt_clk_en", {31'd0, cpu_clk_en}, 32'd0);
        checkOutput("step_halt_reset",  {31'd0, cpu_reset},  32'd1);

        // Run 10 cycles, redundant RUN, HALT, then LOAD mid-run
        cpu_adr = 4'd5;
        applyStimulus(C_RUN);
        checkOutput("run_state",     {29'd0, state},      32'd2);
        checkOutput("run_cpu_reset", {31'd0, cpu_reset},  32'd1);
        checkOutput("run_clk_en",    {31'd0, cpu_clk_en}, 32'd1);
        for (int i = 0; i < 10; i++) tick();
        applyStimulus(C_RUN);
        checkOutput("run_ignore_state", {29'd0, state}, 32'd2);
        applyStimulus(C_HALT);
        checkOutput("halt_state",  {29'd0, state},      32'd4);
        checkOutput("halt_clk_en", {31'd0, cpu_clk_en}, 32'd0);
        applyStimulus(C_HALT);
        checkOutput("halt_noop_state", {29'd0, state}, 32'd4);
        applyStimulus(C_RUN);
        tick();
        tick();
        cpu_adr = 4'd0;
        applyStimulus(C_LOAD);
        checkOutput("midrun_load_state", {29'd0, state},     32'd1);
        checkOutput("midrun_cpu_reset",  {31'd0, cpu_reset}, 32'd0);
        checkOutput("midrun_wr_ready",   {31'd0, wr_ready},  32'd1);

        // Seven beats, then async reset while beat 7 is presented
        wr_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wr_data = 8'h70 + 8'(i);
            tick();
            if (i == 0) checkOutput("midrun_wptr0", {24'd0, cpu_dout}, 32'h70);
        end
        wr_data = 8'h77;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("areset_state",    {29'd0, state},    32'd0);
        checkOutput("areset_wr_ready", {31'd0, wr_ready}, 32'd0);
        for (int a = 0; a < 16; a++) begin
            readCheck("areset_mem", 4'(a), 8'h00);
        end
        wr_valid = 1'b0;
        #3;
        reset = 1'b1;
        tick();

        // Reload after reset starts at address 0
        cpu_adr = 4'd0;
        applyStimulus(C_LOAD);
        wr_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_data = 8'h90 + 8'(i);
            tick();
            if (i == 0) checkOutput("reload_adr0", {24'd0, cpu_dout}, 32'h90);
        end
        wr_valid = 1'b0;
        checkOutput("reload_done", {31'd0, load_done}, 32'd1);
        readCheck("reload_adr1", 4'd1, 8'h91);
        tick();

`ifdef DL166_PROG_CTRL_BP_EN
        // Breakpoint at address 3 halts before executing it, resume passes it
        bp_adr  = 4'd3;
        cpu_adr = 4'd0;
        applyStimulus(C_RUN);
        cpu_adr = 4'd1;
        tick();
        cpu_adr = 4'd2;
        tick();
        cpu_adr = 4'd3;
        #1;
        checkOutput("bp_clk_en_drop", {31'd0, cpu_clk_en}, 32'd0);
        tick();
        checkOutput("bp_halt_state", {29'd0, state},  32'd4);
        checkOutput("bp_hit_set",    {31'd0, bp_hit}, 32'd1);
        applyStimulus(C_RUN);
        checkOutput("bp_resume_state",  {29'd0, state},      32'd2);
        checkOutput("bp_hit_clear",     {31'd0, bp_hit},     32'd0);
        checkOutput("bp_resume_clk_en", {31'd0, cpu_clk_en}, 32'd1);
        cpu_adr = 4'd4;
        tick();
        checkOutput("bp_passed_state", {29'd0, state}, 32'd2);
        applyStimulus(C_HALT);
`else
        // Without the comparator, reaching bp_adr has no effect
        bp_adr  = 4'd3;
        cpu_adr = 4'd3;
        applyStimulus(C_RUN);
        tick();
        tick();
        checkOutput("nobp_state",  {29'd0, state},      32'd2);
        checkOutput("nobp_clk_en", {31'd0, cpu_clk_en}, 32'd1);
        checkOutput("nobp_hit",    {31'd0, bp_hit},     32'd0);
        applyStimulus(C_HALT);
`endif
        checkOutput("final_halt", {29'd0, state}, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dl166_prog_ctrl.md
# dl166_prog_ctrl

Program-memory controller and run sequencer for the DL166 4-bit CPU. Owns the 16x8 instruction store and shares it between a byte-stream loader (write) and the CPU fetch port (read). Sequences the CPU through held-in-reset, load, free-run, single-step and halt, driving the CPU's active-low reset and a clock enable. Sits between the board-level loader/debug logic and the CPU's `adr`/`dout`/`reset` pins.

## Interface
- `DEPTH_LOG2`, 4, program-address width; store depth is 2^DEPTH_LOG2
- `IWIDTH`, 8, instruction width
- `clk` in 1: sole clock
- `reset` in 1: asynchronous, active-low
- `cmd` in 2: 00 HALT, 01 LOAD, 10 RUN, 11 STEP
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake
- `wr_data` in IWIDTH, `wr_valid` in 1 / `wr_ready` out 1: loader byte stream
- `cpu_adr` in DEPTH_LOG2: CPU program counter
- `cpu_dout` out IWIDTH: instruction at `cpu_adr`
- `cpu_reset` out 1: active-low reset to the CPU
- `cpu_clk_en` out 1: CPU advances on `clk` only when high
- `state` out 3: current FSM state code
- `load_done` out 1: one-cycle pulse after last load byte
- `bp_adr` in DEPTH_LOG2, `bp_hit` out 1: breakpoint (see Configuration)

## Operation
- States: IDLE=0, LOAD=1, RUN=2, STEP=3, HALT=4.
- IDLE (after reset): `cpu_reset`=0, `cpu_clk_en`=1, `cmd_ready`=1. LOAD -> LOAD; RUN -> RUN; STEP -> STEP; HALT -> HALT.
- LOAD: `cpu_reset`=0, `wr_ready`=1, `cmd_ready`=0. Each `wr_valid&&wr_ready` beat writes `wr_data` to `mem[wptr]`, `wptr`++. Beat at `wptr`=2^DEPTH_LOG2-1: pointer wraps to 0, `load_done` pulses next cycle, state -> IDLE. Entering LOAD clears `wptr` to 0.
- RUN: `cpu_reset`=1, `cpu_clk_en`=1. HALT -> HALT; STEP -> STEP; LOAD -> LOAD; RUN ignored (accepted, no effect).
- STEP: `cpu_reset`=1, `cpu_clk_en`=1 for exactly one cycle, then HALT unconditionally. `cmd_ready`=0 in STEP.
- HALT: `cpu_reset`=1, `cpu_clk_en`=0, CPU state frozen. RUN/STEP/LOAD per above; HALT no effect.
- `wr_ready`=0 outside LOAD; beats outside LOAD dropped.
- `cpu_dout` = `mem[cpu_adr]`, combinational, all states.
- Store is flops; reset clears every word to 0x00 (MOV r0,r0, a no-op).
- LOAD from RUN/HALT re-asserts `cpu_reset`=0 same cycle state becomes LOAD; CPU restarts at address 0 on next RUN/STEP.

## Timing
- Reset values: `state`=IDLE, `cpu_reset`=0, `cpu_clk_en`=1, `cmd_ready`=1, `wr_ready`=0, `load_done`=0, `bp_hit`=0, `wptr`=0.
- Command accepted on `cmd_valid&&cmd_ready` at edge N; new state and its outputs valid after edge N.
- Load write latency 1: byte written at edge N readable on `cpu_dout` after edge N.
- `load_done` high exactly one cycle, the cycle state first reads IDLE after LOAD.
- All outputs decode from registered state (plus combinational breakpoint gating).
- Asynchronous reset mid-LOAD: partial contents cleared to 0x00, `wptr`=0.

## Configuration
- `DL166_PROG_CTRL_BP_EN` defined: in RUN, when `cpu_adr`==`bp_adr`, `cpu_clk_en` drops combinationally that cycle (instruction at breakpoint not executed), state -> HALT, `bp_hit` set sticky; cleared on next accepted RUN/STEP. Compare masked on first RUN cycle after entry so RUN from a breakpoint proceeds. STEP ignores breakpoint.
- Undefined: no comparator; `bp_adr` unused; `bp_hit` tied 0.

## Structure
- Shared package `dl166_pkg`: state encodings, command encodings, `DL166_ADDR_W`=4, `DL166_INSTR_W`=8.
- One sub-module: `dl166_prog_mem` (flop array, sync write, async read, reset-to-zero); FSM and handshakes in top.

## Test plan
- Reset, LOAD, 16 beats 0xA0..0xAF with `wr_valid` held -> `load_done` pulse after 16th beat, state IDLE, `cpu_adr`=5 gives `cpu_dout`=0xA5.
- LOAD with `wr_valid` toggling every other cycle -> still exactly 16 writes, no skipped/duplicated address, `cmd_ready`=0 throughout.
- From IDLE, STEP -> `cpu_clk_en` high one cycle with `cpu_reset`=1, then HALT with `cpu_clk_en`=0.
- RUN 10 cycles, HALT, LOAD mid-run -> `cpu_reset`=0 same cycle state=LOAD; `wptr` restarts at 0.
- Async reset asserted at load beat 7 -> all words read 0x00, state IDLE, `wr_ready`=0.
- With `DL166_PROG_CTRL_BP_EN`, `bp_adr`=3, RUN -> halt with `cpu_adr`=3, `bp_hit`=1; RUN again -> passes address 3, `bp_hit`=0.
